// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - RISC-V load/store initiator for the word-wide mem/IO bus
//
// Purpose: accepts one load/store at a time. It drives mem_addr/mem_OE/mem_WE/mem_wdata
// and returns extended load data after a fixed read latency. Sub-word RAM stores use
// read-modify-write because the bus has no byte enables.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_store, req_funct3 request kind and RISC-V size/sign code
//   req_addr, req_wdata   byte address, right-aligned store data
//   resp_valid/rdata/err  one-cycle response strobe, load data, error flag
//   mem_addr/OE/WE        bus address and read/write enables
//   mem_wdata, mem_rdata  bus write and read data
// Configuration: define LSU_ALIGN_CHECK_EN to report misaligned non-IO halves/words
// as errors; otherwise the lane is forced to alignment.

module lsu_bus_master #(
  parameter int MEM_RD_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_OE,
  output logic        mem_WE,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [3:0] RD_LAST = 4'(MEM_RD_LATENCY - 1);

  state_t      state;
  logic [3:0]  rd_cnt;
  logic        cap_store;
  logic        cap_io;
  logic [2:0]  cap_funct3;
  logic [1:0]  cap_lane;
  logic [15:0] cap_wdata;

  logic        req_io;
  logic        req_bad;
  logic        req_rmw;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Request classification, evaluated on the live request at the accept edge.
  always_comb begin
    req_io  = (req_addr[31:8] == 24'hFFFFFF) || (req_addr[31:8] == 24'h00FFFF);
    req_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
              (req_store && req_funct3[2]);
`ifdef LSU_ALIGN_CHECK_EN
    if (!req_io && (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))))
      req_bad = 1'b1;
`endif
    // Only legal stores reach this, so funct3 is 000, 001 or 010 here.
    req_rmw = req_store && !req_io && (req_funct3 != 3'b010);
  end

  // Lane extraction. A half uses lane[1] only and a word ignores the lane, which
  // forces misaligned accesses onto an aligned lane when no alignment error is raised.
  always_comb begin
    byte_v    = mem_rdata[{cap_lane, 3'b000} +: 8];
    half_v    = cap_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    if (!cap_io) begin
      case (cap_funct3[1:0])
        2'b00:   load_data = {{24{byte_v[7] & ~cap_funct3[2]}}, byte_v};
        2'b01:   load_data = {{16{half_v[15] & ~cap_funct3[2]}}, half_v};
        default: load_data = mem_rdata;
      endcase
    end
  end

  // Read-modify-write merge for SB/SH: replace the addressed lane(s) in the read word.
  always_comb begin
    merge_data = mem_rdata;
    if (cap_funct3[1:0] == 2'b00)
      merge_data[{cap_lane, 3'b000} +: 8] = cap_wdata[7:0];
    else
      merge_data[{cap_lane[1], 4'b0000} +: 16] = cap_wdata[15:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      cap_store  <= 1'b0;
      cap_io     <= 1'b0;
      cap_funct3 <= '0;
      cap_lane   <= '0;
      cap_wdata  <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_OE     <= 1'b0;
      mem_WE     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_store  <= req_store;
            cap_io     <= req_io;
            cap_funct3 <= req_funct3;
            cap_lane   <= req_addr[1:0];
            cap_wdata  <= req_wdata[15:0];
            mem_addr   <= req_addr;
            req_ready  <= 1'b0;
            if (req_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_store || req_rmw) begin
              state  <= RD;
              rd_cnt <= '0;
              mem_OE <= 1'b1;
            end else begin
              state     <= WR;
              mem_WE    <= 1'b1;
              mem_wdata <= req_wdata;
            end
          end
        end
        RD: begin
          if (rd_cnt == RD_LAST) begin
            mem_OE <= 1'b0;
            if (cap_store) begin
              state     <= WR;
              mem_WE    <= 1'b1;
              mem_wdata <= merge_data;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= load_data;
            end
          end else begin
            rd_cnt <= rd_cnt + 4'd1;
          end
        end
        WR: begin
          mem_WE     <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb/tb_lsu_bus_master.sv - self-checking bench for lsu_bus_master
module tb_lsu_bus_master;

  localparam int L = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_OE;
  logic        mem_WE;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // observations of the last transaction
  int          lat, oe_n, we_n;
  logic [31:0] wseen, rd;
  bit          er, aok, both, rdy_bad;

  lsu_bus_master #(.MEM_RD_LATENCY(L)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_OE(mem_OE), .mem_WE(mem_WE),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  function automatic bit m_io(input logic [31:0] a);
    return (a[31:8] == 24'hFFFFFF) || (a[31:8] == 24'h00FFFF);
  endfunction

  function automatic bit m_err(input bit st, input int f3, input logic [31:0] a);
    bit e;
    e = (f3 == 3) || (f3 == 6) || (f3 == 7) || (st && f3 >= 4);
`ifdef LSU_ALIGN_CHECK_EN
    if (!m_io(a) && (((f3 % 4 == 1) && (a % 2 != 0)) || ((f3 % 4 == 2) && (a % 4 != 0))))
      e = 1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    int off;
    off = int'(a % 4);
    if (m_io(a) || f3 % 4 == 2) return w;
    if (f3 % 4 == 0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (f3 < 4 && v >= 128) v = v + 32'hFFFFFF00;
    end else begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 < 4 && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input int f3, input logic [31:0] a,
                                          input logic [31:0] wd, input logic [31:0] w);
    int sh;
    if (m_io(a) || f3 == 2) return wd;
    if (f3 == 0) begin
      sh = 8 * int'(a % 4);
      return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end
    sh = 16 * int'((a % 4) / 2);
    return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
  endfunction

  // ---------------- transaction driver / monitor ----------------
  // Called #1 after an edge with the DUT idle; returns #1 after an edge with it idle again.
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word);
    req_valid = 1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    mem_rdata = $urandom;
    @(posedge Clk); #1;
    req_valid = 0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1; oe_n = 0; we_n = 0; wseen = 0; rd = 0; er = 0;
    aok = 1; both = 0; rdy_bad = 0;
    forever begin
      if (mem_OE && mem_WE) both = 1;
      if ((mem_OE || mem_WE) && mem_addr !== a) aok = 0;
      if (req_ready) rdy_bad = 1;
      if (mem_OE) begin
        oe_n++;
        mem_rdata = (oe_n == L) ? word : $urandom;
      end
      if (mem_WE) begin
        we_n++;
        wseen = mem_wdata;
      end
      if (resp_valid) begin
        rd = resp_rdata; er = resp_err;
        break;
      end
      if (lat >= 40) begin
        lat = -1;
        break;
      end
      @(posedge Clk); #1;
      lat++;
    end
    @(posedge Clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    Reset = 1; req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_rdata = 0;
    repeat (3) @(posedge Clk);
    #1 Reset = 0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b exp 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got %h exp 0", resp_rdata); end
    checks++; if (mem_OE !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", mem_OE); end
    checks++; if (mem_WE !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", mem_WE); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", mem_wdata); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] as  [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
    logic [31:0] exs [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00001234};
    run_txn(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", er); end
    checks++; if (lat != L + 1) begin errors++; $display("FAIL lw_latency got %0d exp %0d", lat, L + 1); end
    checks++; if (oe_n != L) begin errors++; $display("FAIL lw_oe_cycles got %0d exp %0d", oe_n, L); end
    checks++; if (we_n != 0) begin errors++; $display("FAIL lw_we_cycles got %0d exp 0", we_n); end
    checks++; if (!aok) begin errors++; $display("FAIL lw_addr got bad exp %h", 32'h100); end
    checks++; if (rdy_bad) begin errors++; $display("FAIL lw_ready_busy got 1 exp 0"); end
    for (int i = 0; i < 4; i++) begin
      run_txn(0, f3s[i], as[i], 32'h0, 32'h80FF1234);
      checks++;
      if (rd !== exs[i] || er !== 1'b0)
        begin errors++; $display("FAIL ext_load%0d got %h/%b exp %h/0", i, rd, er, exs[i]); end
    end
  endtask

  task automatic test_rmw_store;
    run_txn(1, 3'b000, 32'h101, 32'h000000AB, 32'h11223344);
    checks++; if (oe_n != L) begin errors++; $display("FAIL sb_oe_cycles got %0d exp %0d", oe_n, L); end
    checks++; if (we_n != 1) begin errors++; $display("FAIL sb_we_cycles got %0d exp 1", we_n); end
    checks++; if (wseen !== 32'h1122AB44) begin errors++; $display("FAIL sb_wdata got %h exp 1122ab44", wseen); end
    checks++; if (lat != L + 2) begin errors++; $display("FAIL sb_latency got %0d exp %0d", lat, L + 2); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sb_resp got %h/%b exp 0/0", rd, er); end
    checks++; if (both) begin errors++; $display("FAIL sb_oe_we_overlap got 1 exp 0"); end
  endtask

  task automatic test_misaligned;
    run_txn(0, 3'b001, 32'h101, 32'h0, 32'h80FF1234);
`ifdef LSU_ALIGN_CHECK_EN
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lh_mis_err got %b/%h exp 1/0", er, rd); end
    checks++; if (lat != 1) begin errors++; $display("FAIL lh_mis_latency got %0d exp 1", lat); end
    checks++; if (oe_n != 0 || we_n != 0) begin errors++; $display("FAIL lh_mis_bus got oe%0d we%0d exp 0 0", oe_n, we_n); end
`else
    checks++; if (er !== 1'b0 || rd !== 32'h00001234) begin errors++; $display("FAIL lh_mis_data got %b/%h exp 0/00001234", er, rd); end
    checks++; if (lat != L + 1) begin errors++; $display("FAIL lh_mis_latency got %0d exp %0d", lat, L + 1); end
`endif
  endtask

  task automatic test_io;
    run_txn(0, 3'b010, 32'hFFFFFFFF, 32'h0, 32'h000002A5);
    checks++; if (rd !== 32'h000002A5 || er !== 1'b0) begin errors++; $display("FAIL io_lw got %h/%b exp 000002a5/0", rd, er); end
    checks++; if (!aok) begin errors++; $display("FAIL io_lw_addr got bad exp ffffffff"); end
    run_txn(1, 3'b000, 32'h00FFFFFF, 32'h00123456, 32'hCAFEF00D);
    checks++; if (oe_n != 0) begin errors++; $display("FAIL io_sb_oe_cycles got %0d exp 0", oe_n); end
    checks++; if (we_n != 1 || wseen !== 32'h00123456) begin errors++; $display("FAIL io_sb_write got %0d/%h exp 1/00123456", we_n, wseen); end
    checks++; if (lat != 2) begin errors++; $display("FAIL io_sb_latency got %0d exp 2", lat); end
  endtask

  task automatic test_reset_mid_rd;
    bit seen;
    req_valid = 1; req_store = 0; req_funct3 = 3'b010; req_addr = 32'h200;
    @(posedge Clk); #1;
    req_valid = 0;
    @(posedge Clk); #1;
    Reset = 1;
    @(posedge Clk); #1;
    Reset = 0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_rd_ready got %b exp 1", req_ready); end
    checks++; if (mem_OE !== 1'b0) begin errors++; $display("FAIL rst_rd_oe got %b exp 0", mem_OE); end
    seen = 0;
    for (int i = 0; i < 2 * L + 4; i++) begin
      if (resp_valid) seen = 1;
      @(posedge Clk); #1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_rd_resp got 1 exp 0"); end
    run_txn(0, 3'b010, 32'h204, 32'h0, 32'h5A5A1234);
    checks++; if (rd !== 32'h5A5A1234 || lat != L + 1) begin errors++; $display("FAIL rst_rd_next got %h/%0d exp 5a5a1234/%0d", rd, lat, L + 1); end
  endtask

  task automatic test_random;
    bit          st, e;
    int          f3;
    logic [31:0] a, wd, w, exp_rd, exp_w;
    int          exp_lat, exp_oe, exp_we;
    for (int n = 0; n < 150; n++) begin
      st = 1'($urandom);
      f3 = $urandom_range(0, 7);
      if ($urandom_range(0, 5) == 0)
        a = {($urandom_range(0, 1) == 1) ? 24'hFFFFFF : 24'h00FFFF, 8'($urandom)};
      else
        a = $urandom & 32'h0000FFFF;
      wd = $urandom; w = $urandom;
      e = m_err(st, f3, a);
      if (e) begin
        exp_lat = 1; exp_oe = 0; exp_we = 0; exp_rd = 0;
      end else if (!st) begin
        exp_lat = L + 1; exp_oe = L; exp_we = 0; exp_rd = m_load(f3, a, w);
      end else if (m_io(a) || f3 == 2) begin
        exp_lat = 2; exp_oe = 0; exp_we = 1; exp_rd = 0;
      end else begin
        exp_lat = L + 2; exp_oe = L; exp_we = 1; exp_rd = 0;
      end
      exp_w = m_store(f3, a, wd, w);
      run_txn(st, 3'(f3), a, wd, w);
      checks++;
      if (er !== e || rd !== exp_rd)
        begin errors++; $display("FAIL rnd%0d_resp st%0d f3%0d a%h got %b/%h exp %b/%h", n, st, f3, a, er, rd, e, exp_rd); end
      checks++;
      if (lat != exp_lat || oe_n != exp_oe || we_n != exp_we)
        begin errors++; $display("FAIL rnd%0d_timing got lat%0d oe%0d we%0d exp lat%0d oe%0d we%0d", n, lat, oe_n, we_n, exp_lat, exp_oe, exp_we); end
      if (exp_we == 1) begin
        checks++;
        if (wseen !== exp_w) begin errors++; $display("FAIL rnd%0d_wdata got %h exp %h", n, wseen, exp_w); end
      end
      checks++;
      if (!aok || both || rdy_bad)
        begin errors++; $display("FAIL rnd%0d_bus got addr_ok%0d overlap%0d ready_busy%0d exp 1 0 0", n, aok, both, rdy_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_rmw_store();
    test_misaligned();
    test_io();
    test_reset_mid_rd();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
